// File: rtl/tlb_op_ctrl_if.sv
// TLB array port bundle: search, read and write strobes with their indices.
// The controller uses the master modport, the TLB array the slave modport.
interface tlb_op_ctrl_if #(
   parameter int IDX_W = 4
);
   logic             s_req;
   logic             s_found;
   logic [IDX_W-1:0] s_index;
   logic             r_req;
   logic [IDX_W-1:0] r_index;
   logic             tlb_we;
   logic [IDX_W-1:0] w_index;

   modport master (
      output s_req,
      input  s_found,
      input  s_index,
      output r_req,
      output r_index,
      output tlb_we,
      output w_index
   );

   modport slave (
      input  s_req,
      output s_found,
      output s_index,
      input  r_req,
      input  r_index,
      input  tlb_we,
      input  w_index
   );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer between pipeline, TLB array and CP0.
// Optional macro TLBWR_RANDOM_EN enables the Random counter used by TLBWR.
module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   output logic             req_ready,
   input  logic             cancel,
   input  logic [IDX_W-1:0] cp0_index,
   tlb_op_ctrl_if.master    tlb,
   output logic             cp0_tlbp_we,
   output logic             cp0_tlbp_found,
   output logic [IDX_W-1:0] cp0_tlbp_index,
   output logic             cp0_tlbr_we,
   output logic [IDX_W-1:0] cp0_random,
   output logic             op_done,
   output logic             refetch
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   localparam logic [1:0]       OP_TLBP  = 2'b00;
   localparam logic [1:0]       OP_TLBR  = 2'b01;
   localparam logic [1:0]       OP_TLBWI = 2'b10;
   localparam logic [1:0]       OP_TLBWR = 2'b11;
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(TLBNUM - 1);

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] wr_rand_idx_s;

`ifdef TLBWR_RANDOM_EN
   logic [IDX_W-1:0] random_q, random_d;

   // Free-running Random counter, wraps from zero back to the top entry
   always_comb begin
      random_d = random_q - IDX_ONE;
      if (random_q == IDX_ZERO) begin
         random_d = IDX_MAX;
      end else begin
         random_d = random_q - IDX_ONE;
      end
   end

   // Random counter register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         random_q <= IDX_MAX;
      end else begin
         random_q <= random_d;
      end
   end

   assign cp0_random    = random_q;
   assign wr_rand_idx_s = random_q;
`else
   assign cp0_random    = IDX_MAX;
   assign wr_rand_idx_s = cp0_index;
`endif

   // Next-state, operand latching and all strobe outputs
   always_comb begin
      state_d            = state_q;
      op_d               = op_q;
      idx_d              = idx_q;
      req_ready          = 1'b0;
      tlb.s_req          = 1'b0;
      tlb.r_req          = 1'b0;
      tlb.r_index        = IDX_ZERO;
      tlb.tlb_we         = 1'b0;
      tlb.w_index        = IDX_ZERO;
      cp0_tlbp_we        = 1'b0;
      cp0_tlbp_found     = 1'b0;
      cp0_tlbp_index     = IDX_ZERO;
      cp0_tlbr_we        = 1'b0;
      op_done            = 1'b0;
      refetch            = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !cancel) begin
               op_d    = req_op;
               state_d = ST_ISSUE;
               if (req_op == OP_TLBWR) begin
                  idx_d = wr_rand_idx_s;
               end else begin
                  idx_d = cp0_index;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            // A flush here kills the op before anything reaches the TLB
            if (cancel) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
               case (op_q)
                  OP_TLBP: begin
                     tlb.s_req = 1'b1;
                  end
                  OP_TLBR: begin
                     tlb.r_req   = 1'b1;
                     tlb.r_index = idx_q;
                  end
                  OP_TLBWI, OP_TLBWR: begin
                     tlb.tlb_we  = 1'b1;
                     tlb.w_index = idx_q;
                  end
                  default: begin
                     tlb.s_req = 1'b0;
                  end
               endcase
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
            op_done = 1'b1;
            refetch = (op_q != OP_TLBP);
            case (op_q)
               OP_TLBP: begin
                  cp0_tlbp_we    = 1'b1;
                  cp0_tlbp_found = tlb.s_found;
                  if (tlb.s_found) begin
                     cp0_tlbp_index = tlb.s_index;
                  end else begin
                     cp0_tlbp_index = IDX_ZERO;
                  end
               end
               OP_TLBR: begin
                  cp0_tlbr_we = 1'b1;
               end
               default: begin
                  cp0_tlbr_we = 1'b0;
               end
            endcase
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched operand registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         op_q    <= 2'b00;
         idx_q   <= IDX_ZERO;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized self-checking bench for tlb_op_ctrl against a transaction-level model.
module tb_tlb_op_ctrl;
   localparam int TLBNUM = 16;
   localparam int IDX_W  = 4;

   logic             clk = 1'b0;
   logic             resetn;
   logic             req_valid;
   logic [1:0]       req_op;
   logic             req_ready;
   logic             cancel;
   logic [IDX_W-1:0] cp0_index;
   logic             cp0_tlbp_we;
   logic             cp0_tlbp_found;
   logic [IDX_W-1:0] cp0_tlbp_index;
   logic             cp0_tlbr_we;
   logic [IDX_W-1:0] cp0_random;
   logic             op_done;
   logic             refetch;

   tlb_op_ctrl_if #(.IDX_W(IDX_W)) tif ();

   tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .req_valid      (req_valid),
      .req_op         (req_op),
      .req_ready      (req_ready),
      .cancel         (cancel),
      .cp0_index      (cp0_index),
      .tlb            (tif.master),
      .cp0_tlbp_we    (cp0_tlbp_we),
      .cp0_tlbp_found (cp0_tlbp_found),
      .cp0_tlbp_index (cp0_tlbp_index),
      .cp0_tlbr_we    (cp0_tlbr_we),
      .cp0_random     (cp0_random),
      .op_done        (op_done),
      .refetch        (refetch)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model: one pending transaction and its age in cycles since acceptance
   bit       pend = 1'b0;
   int       age  = 0;
   int       m_op = 0;
   int       m_idx = 0;
   int       cyc  = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int exp_random();
`ifdef TLBWR_RANDOM_EN
      return (TLBNUM - 1) - (cyc % TLBNUM);
`else
      return TLBNUM - 1;
`endif
   endfunction

   task automatic check_quiet(input string pfx);
      check_val({pfx, "_s_req"}, int'(tif.s_req), 0);
      check_val({pfx, "_r_req"}, int'(tif.r_req), 0);
      check_val({pfx, "_tlb_we"}, int'(tif.tlb_we), 0);
      check_val({pfx, "_w_index"}, int'(tif.w_index), 0);
      check_val({pfx, "_r_index"}, int'(tif.r_index), 0);
      check_val({pfx, "_op_done"}, int'(op_done), 0);
      check_val({pfx, "_refetch"}, int'(refetch), 0);
      check_val({pfx, "_tlbp_we"}, int'(cp0_tlbp_we), 0);
      check_val({pfx, "_tlbr_we"}, int'(cp0_tlbr_we), 0);
      check_val({pfx, "_tlbp_index"}, int'(cp0_tlbp_index), 0);
   endtask

   // One clock cycle: drive at posedge+1, compare mid-cycle, advance the model at the edge
   task automatic step(input logic v, input logic [1:0] op, input logic cn,
                       input logic [IDX_W-1:0] ci, input logic sf, input logic [IDX_W-1:0] si);
      bit issue;
      bit resp;
      int er;
      req_valid   = v;
      req_op      = op;
      cancel      = cn;
      cp0_index   = ci;
      tif.s_found = sf;
      tif.s_index = si;
      #3;
      issue = pend && (age == 1) && !cn;
      resp  = pend && (age == 2);
      er    = exp_random();
      check_val("req_ready", int'(req_ready), int'(!pend));
      check_val("s_req", int'(tif.s_req), int'(issue && m_op == 0));
      check_val("r_req", int'(tif.r_req), int'(issue && m_op == 1));
      check_val("r_index", int'(tif.r_index), (issue && m_op == 1) ? m_idx : 0);
      check_val("tlb_we", int'(tif.tlb_we), int'(issue && m_op >= 2));
      check_val("w_index", int'(tif.w_index), (issue && m_op >= 2) ? m_idx : 0);
      check_val("op_done", int'(op_done), int'(resp));
      check_val("refetch", int'(refetch), int'(resp && m_op != 0));
      check_val("tlbp_we", int'(cp0_tlbp_we), int'(resp && m_op == 0));
      check_val("tlbp_found", int'(cp0_tlbp_found), int'(resp && m_op == 0 && sf));
      check_val("tlbp_index", int'(cp0_tlbp_index), (resp && m_op == 0 && sf) ? int'(si) : 0);
      check_val("tlbr_we", int'(cp0_tlbr_we), int'(resp && m_op == 1));
      check_val("cp0_random", int'(cp0_random), er);
      @(posedge clk);
      if (!pend) begin
         if (v && !cn) begin
            pend = 1'b1;
            age  = 1;
            m_op = int'(op);
`ifdef TLBWR_RANDOM_EN
            m_idx = (op == 2'b11) ? er : int'(ci);
`else
            m_idx = int'(ci);
`endif
         end
      end else if (age == 1) begin
         if (cn) pend = 1'b0;
         else age = 2;
      end else begin
         pend = 1'b0;
      end
      cyc++;
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      #1;
      check_quiet("rst");
      check_val("rst_random", int'(cp0_random), TLBNUM - 1);
      check_val("rst_ready", int'(req_ready), 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      pend = 1'b0;
      cyc  = 0;
   endtask

   initial begin
      req_valid   = 1'b0;
      req_op      = 2'b00;
      cancel      = 1'b0;
      cp0_index   = 4'd0;
      tif.s_found = 1'b0;
      tif.s_index = 4'd0;
      @(posedge clk);
      #1;
      apply_reset();

      for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0);

      // TLBP hit at index 9
      step(1'b1, 2'b00, 1'b0, 4'd2, 1'b0, 4'd0);
      step(1'b0, 2'b00, 1'b0, 4'd2, 1'b0, 4'd0);
      step(1'b0, 2'b00, 1'b0, 4'd2, 1'b1, 4'd9);
      // TLBP miss with junk index
      step(1'b1, 2'b00, 1'b0, 4'd2, 1'b0, 4'd0);
      step(1'b0, 2'b00, 1'b0, 4'd2, 1'b0, 4'd0);
      step(1'b0, 2'b00, 1'b0, 4'd2, 1'b0, 4'd7);
      // TLBWI index 5, request held to confirm req_ready stays low
      step(1'b1, 2'b10, 1'b0, 4'd5, 1'b0, 4'd0);
      step(1'b1, 2'b10, 1'b0, 4'd5, 1'b0, 4'd0);
      step(1'b1, 2'b10, 1'b0, 4'd5, 1'b0, 4'd0);
      // TLBWR with cp0_index 3
      step(1'b1, 2'b11, 1'b0, 4'd3, 1'b0, 4'd0);
      step(1'b0, 2'b11, 1'b0, 4'd3, 1'b0, 4'd0);
      step(1'b0, 2'b11, 1'b0, 4'd3, 1'b0, 4'd0);
      // Request with cancel is not accepted
      step(1'b1, 2'b10, 1'b1, 4'd6, 1'b0, 4'd0);
      // TLBWI cancelled in ISSUE
      step(1'b1, 2'b10, 1'b0, 4'd6, 1'b0, 4'd0);
      step(1'b0, 2'b10, 1'b1, 4'd6, 1'b0, 4'd0);
      step(1'b0, 2'b10, 1'b0, 4'd6, 1'b0, 4'd0);
      // TLBR with cancel during RESP still completes
      step(1'b1, 2'b01, 1'b0, 4'd12, 1'b0, 4'd0);
      step(1'b0, 2'b01, 1'b0, 4'd12, 1'b0, 4'd0);
      step(1'b0, 2'b01, 1'b1, 4'd12, 1'b0, 4'd0);
      // Async reset asserted in the middle of an ISSUE cycle
      step(1'b1, 2'b10, 1'b0, 4'd11, 1'b0, 4'd0);
      apply_reset();

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(3, 0) != 0),
              2'($urandom_range(3, 0)),
              ($urandom_range(7, 0) == 0),
              4'($urandom_range(TLBNUM - 1, 0)),
              1'($urandom_range(1, 0)),
              4'($urandom_range(TLBNUM - 1, 0)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences the TLB-maintenance instructions TLBP, TLBR, TLBWI and TLBWR between the memory-stage pipeline, the TLB array and the CP0 register file.
- Accepts one operation at a time and drives the TLB search, read or write port for one cycle.
- Then commits results to CP0 (Index, EntryHi/EntryLo0/1) through strobes, and requests a pipeline refetch when the mapping may have changed.
- Owns the Random counter used by TLBWR.

Parameters:
TLBNUM, 16, number of TLB entries (power of two, 2..64)
IDX_W, 4, index width, equals log2(TLBNUM)

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  memory stage presents a TLB op
req_op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
req_ready  out  1  controller can accept an op (high only in IDLE)
cancel  in  1  exception/eret flush of the in-flight op
cp0_index  in  IDX_W  current CP0 Index.Index field
s_req  out  1  TLB search strobe (search key is EntryHi, supplied outside this block)
s_found  in  1  search hit, valid the cycle after s_req
s_index  in  IDX_W  hit index, valid with s_found
r_req  out  1  TLB read strobe
r_index  out  IDX_W  TLB read index
tlb_we  out  1  TLB write enable (data from CP0 EntryHi/Lo)
w_index  out  IDX_W  TLB write index
cp0_tlbp_we  out  1  commit probe result to CP0 Index
cp0_tlbp_found  out  1  probe hit (CP0 sets Index.P = ~found)
cp0_tlbp_index  out  IDX_W  probe hit index
cp0_tlbr_we  out  1  latch TLB read data into EntryHi/EntryLo0/EntryLo1
cp0_random  out  IDX_W  Random register value for mfc0
op_done  out  1  one-cycle pulse, op complete
refetch  out  1  one-cycle pulse with op_done, flush and refetch from next PC

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all strobe outputs 0; w_index/r_index/cp0_tlbp_index 0.
  - random = TLBNUM-1; latched op and index 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid && !cancel: latch op; latch index (cp0_index for TLBR/TLBWI, cp0_random for TLBWR); go to ISSUE.
  - req_valid && cancel: no accept, stay in IDLE.
- ISSUE (exactly 1 cycle), driven from the latched op and index:
  - TLBP: s_req=1.
  - TLBR: r_req=1, r_index=latched index.
  - TLBWI/TLBWR: tlb_we=1, w_index=latched index.
  - cancel=1 here: all ISSUE strobes forced 0 combinationally, go to IDLE, no RESP, no op_done.
  - Otherwise go to RESP.
- RESP (exactly 1 cycle):
  - op_done=1; refetch=1 for TLBR/TLBWI/TLBWR, 0 for TLBP.
  - TLBP: cp0_tlbp_we=1, cp0_tlbp_found=s_found, cp0_tlbp_index=s_index (0 on miss).
  - TLBR: cp0_tlbr_we=1.
  - cancel is ignored in RESP (the op has already committed to the TLB).
  - Always go to IDLE.
- Latency and throughput:
  - Accept at edge T; ISSUE strobes during T+1; RESP/op_done during T+2.
  - req_ready is high again at T+3; max throughput one op per 3 cycles.
- Random counter:
  - Decrements every cycle; wraps 0 -> TLBNUM-1.
  - Free-running, including during ops and cancel.
  - TLBWR uses the value sampled at the accept edge.
- Strobes are never asserted outside their state; at most one of s_req/r_req/tlb_we is high in any cycle.
- Unlisted req_op encodings do not exist (2-bit field is fully decoded).

Optional Feature:
- Macro TLBWR_RANDOM_EN.
- Defined: TLBWR writes at the latched Random value; cp0_random is the live counter.
- Undefined:
  - Counter removed; cp0_random tied to TLBNUM-1.
  - TLBWR behaves exactly as TLBWI (w_index = cp0_index), still with refetch=1.

Test Plan:
- Reset release, idle 5 cycles -> req_ready=1, all strobes 0; cp0_random = 15,14,13,12,11 (macro on).
- TLBP accepted at T, s_found=1, s_index=9 at T+2 -> s_req at T+1; op_done, cp0_tlbp_we=1, found=1, index=9, refetch=0 at T+2.
- TLBP with s_found=0 -> cp0_tlbp_found=0, cp0_tlbp_index=0, refetch=0.
- TLBWI with cp0_index=5 -> tlb_we=1, w_index=5 at T+1; op_done=refetch=1 at T+2; req_ready=0 through T+2.
- TLBWR accepted when cp0_random=0 -> w_index=0; next cycle cp0_random=15 (wrap). Macro off, cp0_index=3 -> w_index=3.
- Cancel cases:
  - TLBWI with cancel=1 during ISSUE -> tlb_we stays 0, no op_done, IDLE next cycle.
  - Cancel during RESP -> op_done still 1.
  - resetn low mid-ISSUE -> all outputs 0 immediately.
